// File: rtl/conv_encoder_tx.sv
// conv_encoder_tx: rate-1/2, K=3 convolutional encoder feeding the Viterbi
// decoder's 16-bit receive input. One byte is accepted per handshake and
// encoded bit-serially, MSB first; the 2-bit trellis state carries across bytes.
// Optional feature macro: CONV_ENC_TERMINATE_EN -- after a word whose byte was
// tagged in_last, an all-zero tail byte is encoded and emitted as an extra word,
// leaving the trellis in state 00.
module conv_encoder_tx #(
  parameter int         N_BITS = 8,
  parameter logic [2:0] G0     = 3'b111,
  parameter logic [2:0] G1     = 3'b101
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [N_BITS-1:0]     data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [2*N_BITS-1:0]   data_enc,
  output logic [1:0]            enc_state
);

  localparam int            CW       = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    OUT  = 2'd2
`ifdef CONV_ENC_TERMINATE_EN
    ,
    TAIL = 2'd3
`endif
  } state_t;

  // Parity of the generator taps applied to the {input, s1, s0} register.
  function automatic logic tap_parity(input logic [2:0] taps, input logic [2:0] regs);
    return ^(taps & regs);
  endfunction

  state_t                fsm_r;
  state_t                fsm_next_s;
  logic [1:0]            trel_r;
  logic [N_BITS-1:0]     shift_r;
  logic [CW-1:0]         cnt_r;
  logic [2*N_BITS-1:0]   word_r;
  logic                  last_r;
  logic [2*N_BITS-1:0]   data_enc_r;
  logic                  out_valid_r;
  logic                  out_last_r;
  logic                  in_ready_r;

  logic                  accept_s;
  logic                  out_hs_s;
  logic                  enc_active_s;
  logic                  final_s;
  logic                  bit_s;
  logic [2:0]            tap_s;
  logic [1:0]            pair_s;
  logic                  tail_start_s;
  logic                  in_tail_s;

  assign accept_s  = in_valid & in_ready_r & (fsm_r == IDLE);
  assign out_hs_s  = out_valid_r & out_ready & (fsm_r == OUT);

`ifdef CONV_ENC_TERMINATE_EN
  assign in_tail_s    = (fsm_r == TAIL);
  // The data word of a terminated frame carries out_last=0, so this selects it.
  assign tail_start_s = out_hs_s & last_r & ~out_last_r;
`else
  assign in_tail_s    = 1'b0;
  assign tail_start_s = 1'b0;
`endif

  assign enc_active_s = (fsm_r == ENC) | in_tail_s;
  assign final_s      = enc_active_s & (cnt_r == CNT_LAST);
  assign bit_s        = shift_r[N_BITS-1];
  assign tap_s        = {bit_s, trel_r};
  assign pair_s       = {tap_parity(G0, tap_s), tap_parity(G1, tap_s)};

  // Next-state logic for the byte-level control FSM.
  always_comb begin
    fsm_next_s = fsm_r;
    case (fsm_r)
      IDLE: begin
        if (accept_s) begin
          fsm_next_s = ENC;
        end else begin
          fsm_next_s = IDLE;
        end
      end
      ENC: begin
        if (final_s) begin
          fsm_next_s = OUT;
        end else begin
          fsm_next_s = ENC;
        end
      end
      OUT: begin
        if (tail_start_s) begin
`ifdef CONV_ENC_TERMINATE_EN
          fsm_next_s = TAIL;
`else
          fsm_next_s = IDLE;
`endif
        end else if (out_hs_s) begin
          fsm_next_s = IDLE;
        end else begin
          fsm_next_s = OUT;
        end
      end
`ifdef CONV_ENC_TERMINATE_EN
      TAIL: begin
        if (final_s) begin
          fsm_next_s = OUT;
        end else begin
          fsm_next_s = TAIL;
        end
      end
`endif
      default: begin
        fsm_next_s = IDLE;
      end
    endcase
  end

  // FSM state and registered handshake flags derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_r       <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      fsm_r       <= fsm_next_s;
      in_ready_r  <= (fsm_next_s == IDLE);
      out_valid_r <= (fsm_next_s == OUT);
    end
  end

  // Encoding datapath: byte capture, bit-serial trellis update, word assembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trel_r     <= 2'b00;
      shift_r    <= '0;
      cnt_r      <= '0;
      word_r     <= '0;
      last_r     <= 1'b0;
      data_enc_r <= '0;
      out_last_r <= 1'b0;
    end else if (accept_s) begin
      shift_r <= data_in;
      last_r  <= in_last;
      cnt_r   <= '0;
      word_r  <= '0;
    end else if (enc_active_s) begin
      shift_r <= {shift_r[N_BITS-2:0], 1'b0};
      cnt_r   <= cnt_r + CW'(1);
      word_r  <= {word_r[2*N_BITS-3:0], pair_s};
      // The tail byte always flushes to 00; forcing it keeps that explicit.
      if (final_s && in_tail_s) begin
        trel_r <= 2'b00;
      end else begin
        trel_r <= {bit_s, trel_r[1]};
      end
      if (final_s) begin
        data_enc_r <= {word_r[2*N_BITS-3:0], pair_s};
`ifdef CONV_ENC_TERMINATE_EN
        out_last_r <= in_tail_s;
`else
        out_last_r <= last_r;
`endif
      end
    end else if (tail_start_s) begin
      shift_r <= '0;
      cnt_r   <= '0;
      word_r  <= '0;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign data_enc  = data_enc_r;
  assign enc_state = trel_r;

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Self-checking bench for conv_encoder_tx: directed cases with fixed expected
// words plus randomised bytes checked against a trellis reference model.
module tb_conv_encoder_tx;

  localparam logic [2:0] G0_T = 3'b111;
  localparam logic [2:0] G1_T = 3'b101;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [7:0]  data_in;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] data_enc;
  logic [1:0]  enc_state;

  int total = 0;
  int bad   = 0;
  logic [1:0] mst;

  conv_encoder_tx #(.N_BITS(8), .G0(3'b111), .G1(3'b101)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .data_enc(data_enc), .enc_state(enc_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Code pair {g0,g1} for input bit b leaving trellis state st={s1,s0}.
  function automatic logic [1:0] code_pair(input logic b, input logic [1:0] st);
    logic [2:0] r;
    int p0;
    int p1;
    r  = {b, st};
    p0 = $countones(G0_T & r) % 2;
    p1 = $countones(G1_T & r) % 2;
    return {p0[0], p1[0]};
  endfunction

  function automatic logic [15:0] model_enc(input logic [7:0] d, input logic [1:0] st_in,
                                            output logic [1:0] st_out);
    logic [15:0] w;
    logic [1:0]  st;
    w  = 16'h0000;
    st = st_in;
    for (int k = 0; k < 8; k++) begin
      w  = (w << 2) | {14'd0, code_pair(d[7-k], st)};
      st = {d[7-k], st[1]};
    end
    st_out = st;
    return w;
  endfunction

  // Decode by picking, at each step, the input bit whose pair matches.
  function automatic logic [7:0] model_dec(input logic [15:0] w, input logic [1:0] st_in);
    logic [7:0] d;
    logic [1:0] st;
    logic       b;
    d  = 8'h00;
    st = st_in;
    for (int k = 0; k < 8; k++) begin
      b  = (code_pair(1'b1, st) == w[15-2*k -: 2]);
      d  = {d[6:0], b};
      st = {b, st[1]};
    end
    return d;
  endfunction

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    data_in  = d;
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Waits for a word, checks it, optionally stalls with ignored in_valid pulses, then consumes it.
  task automatic recv(input string tag, input logic [15:0] ew, input logic el, input logic [1:0] es,
                      input int stall, output logic [15:0] got);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, 32'd8);
    check({tag, "_word"}, {16'd0, data_enc}, {16'd0, ew});
    check({tag, "_last"}, {31'd0, out_last}, {31'd0, el});
    check({tag, "_state"}, {30'd0, enc_state}, {30'd0, es});
    got = data_enc;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom % 2);
      data_in  = 8'($urandom);
      @(posedge clk); #1;
      check({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_stall_word"}, {16'd0, data_enc}, {16'd0, ew});
      check({tag, "_stall_ready"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  // One byte through the model-checked path, including the tail word when termination is built in.
  task automatic xfer(input logic [7:0] d, input logic l, input int stall);
    logic [15:0] w;
    logic [15:0] got;
    logic [1:0]  st0;
    logic [1:0]  st1;
    st0 = mst;
    w   = model_enc(d, st0, st1);
    mst = st1;
    send(d, l);
`ifdef CONV_ENC_TERMINATE_EN
    recv("rnd", w, 1'b0, mst, stall, got);
    check("rnd_decode", {24'd0, model_dec(got, st0)}, {24'd0, d});
    if (l) begin
      st0 = mst;
      w   = model_enc(8'h00, st0, st1);
      mst = 2'b00;
      recv("rnd_tail", w, 1'b1, 2'b00, 0, got);
    end
`else
    recv("rnd", w, l, mst, stall, got);
    check("rnd_decode", {24'd0, model_dec(got, st0)}, {24'd0, d});
`endif
  endtask

  initial begin
    logic [15:0] got;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    data_in   = 8'h00;
    out_ready = 1'b0;
    mst       = 2'b00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_data_enc", {16'd0, data_enc}, 32'd0);
    check("rst_state", {30'd0, enc_state}, 32'd0);
    rst = 1'b1;
    #1;
    check("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("rel_in_ready_high", {31'd0, in_ready}, 32'd1);

    // Single byte 0x80
    send(8'h80, 1'b0);
    recv("t1", 16'hEC00, 1'b0, 2'b00, 0, got);
    check("t1_in_ready_back", {31'd0, in_ready}, 32'd1);

    // Back-to-back 0xFF then 0x00 with carried state
    send(8'hFF, 1'b0);
    recv("t2a", 16'hDAAA, 1'b0, 2'b11, 0, got);
    send(8'h00, 1'b0);
    recv("t2b", 16'h7000, 1'b0, 2'b00, 0, got);

    // Frame end on 0xFF
    send(8'hFF, 1'b1);
`ifdef CONV_ENC_TERMINATE_EN
    recv("t5_data", 16'hDAAA, 1'b0, 2'b11, 0, got);
    check("t5_no_ready_before_tail", {31'd0, in_ready}, 32'd0);
    recv("t5_tail", 16'h7000, 1'b1, 2'b00, 0, got);
    mst = 2'b00;
`else
    recv("t5", 16'hDAAA, 1'b1, 2'b11, 0, got);
    mst = 2'b11;
`endif

    // Long backpressure with ignored in_valid pulses
    xfer(8'h5A, 1'b0, 20);

    // Reset in the middle of encoding
    send(8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_data_enc", {16'd0, data_enc}, 32'd0);
    check("mid_rst_state", {30'd0, enc_state}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_in_ready_back", {31'd0, in_ready}, 32'd1);
    send(8'h80, 1'b0);
    recv("t4", 16'hEC00, 1'b0, 2'b00, 0, got);
    mst = 2'b00;

    // Randomised bytes against the reference model
    for (int i = 0; i < 24; i++) begin
      xfer(8'($urandom), 1'($urandom % 4 == 0), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_encoder_tx.md
Name: conv_encoder_tx

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of the pipelined Viterbi decoder.
- Accepts one data byte per valid/ready handshake and encodes it bit-serially, MSB first.
- Emits one 16-bit encoded word in exactly the format the decoder's 16-bit receive input expects.
- The 2-bit trellis state carries across bytes. Zero-tail termination is an optional feature.

Parameters:
- N_BITS, 8: data bits per input word; output word is 2*N_BITS bits.
- G0, 3'b111: generator polynomial for the first (upper) code bit; bit2 taps the input bit, bit1 taps s1, bit0 taps s0.
- G1, 3'b101: generator polynomial for the second (lower) code bit; same tap order.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  data_in is valid.
- in_ready  output  1  block can accept a byte.
- in_last  input  1  byte is the final byte of a frame; sampled with the in handshake.
- data_in  input  N_BITS  byte to encode.
- out_valid  output  1  data_enc is valid.
- out_ready  input  1  downstream accepts data_enc.
- out_last  output  1  qualifies the final word of a frame.
- data_enc  output  2*N_BITS  encoded word.
- enc_state  output  2  current trellis state {s1,s0}, for debug and verification.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; {s1,s0}=00; bit counter=0.
  - out_valid=0, out_last=0, data_enc=0, in_ready=0 while rst is low.
  - in_ready rises on the first clk edge after rst deasserts.
- Reset mid-operation aborts any byte in ENC or OUT with no output. State clears to 00.
- Encoding of bit b from state {s1,s0}:
  - g0 = XOR of (G0 & {b,s1,s0}); g1 = XOR of (G1 & {b,s1,s0}).
  - Next state = {b,s1}.
- Bit ordering:
  - data_in[N_BITS-1] is encoded first.
  - The pair for the k-th processed bit (k=0 first) goes to data_enc[2*N_BITS-1-2k -: 2] as {g0,g1}, with g0 in the higher bit.
- FSM states IDLE, ENC, OUT, plus TAIL with the optional feature.
  - IDLE: in_ready=1. On in_valid&in_ready, latch data_in and in_last into a shift register, clear the counter, go to ENC.
  - ENC: in_ready=0. One bit is processed per cycle. After exactly N_BITS cycles the full word is loaded into data_enc and the FSM goes to OUT.
  - OUT: out_valid=1. data_enc, out_last and enc_state are held stable until out_ready=1. On the handshake, go to IDLE (or TAIL, see Optional Feature); out_valid drops the next cycle.
- Latency: byte accepted at edge N; out_valid is asserted after edge N+N_BITS; the word is consumed at the earliest edge N+N_BITS+1.
- Throughput: at most one byte per N_BITS+2 cycles.
- Backpressure: out_ready=0 holds OUT indefinitely. in_ready stays 0 for the whole time; no byte is lost or overwritten.
- in_valid while in_ready=0: ignored; the upstream block must hold it.
- out_ready asserted outside OUT: no effect.
- in_last without the feature: passes through to out_last on the same word. The trellis state is not cleared.

Optional Feature:
- Macro: CONV_ENC_TERMINATE_EN.
- Defined:
  - After the OUT handshake of a word whose latched in_last=1, the FSM enters TAIL and encodes an all-zero byte through the same ENC datapath.
  - This emits one extra word; the data word's out_last=0 and the tail word's out_last=1.
  - After the tail, state is forced to 00.
  - in_ready stays 0 until the tail word is consumed.
- Undefined: the TAIL state and the extra word do not exist; behaviour is as described above.

Test Plan:
- Reset then byte 0x80 with out_ready=1 -> data_enc=0xEC00 exactly 8 cycles after acceptance; enc_state=00; in_ready back high after the handshake.
- Byte 0xFF then 0x00 back-to-back, state carried -> words 0xDAAA (enc_state=11) then 0x7000 (enc_state=00).
- Hold out_ready=0 for 20 cycles in OUT -> data_enc and out_valid stable, in_ready=0 throughout, and in_valid pulses during the stall are ignored.
- Assert rst low during ENC of 0xFF -> all outputs 0 immediately; next byte 0x80 yields 0xEC00, proving state was cleared.
- in_last=1 with 0xFF:
  - Without CONV_ENC_TERMINATE_EN -> one word 0xDAAA with out_last=1, enc_state=11.
  - With it -> 0xDAAA (out_last=0) then tail 0x7000 (out_last=1), enc_state=00.
- Randomised bytes compared against a reference encoder model -> every word matches, and the model's decoded bytes match the inputs.
